tcdm_varlat_bank_arbiter: RTL and testbench

Per-bank arbiter for the variable-latency TCDM crossbar. It sits between the per-master address decoders and one memory bank. Each cycle it picks one of `NumIn` requesting masters round-robin and forwards that request to the bank. It records the winner's index in an in-order ID FIFO and routes each bank response (`vld_i`/`rdata_i`) back to the master that issued it, whatever the bank's response latency.

---
 rtl/tcdm_varlat_pkg.sv | 13 +
 rtl/tcdm_varlat_id_fifo.sv | 62 ++++++
 rtl/tcdm_varlat_bank_arbiter.sv | 94 +++++++++
 tb/tb_tcdm_varlat_bank_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tcdm_varlat_pkg.sv
// Shared definitions for the variable-latency TCDM crossbar.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tcdm_varlat_pkg;

    localparam int unsigned MaxOutstandingDefault = 4;

    // Index width for a set of n items; a single item still gets one (constant-zero) bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tcdm_varlat_id_fifo.sv
// In-order ID FIFO remembering which master owns each in-flight bank transaction.
// Latency: push visible at the head one cycle later; head read is combinational.
// Backpressure: push ignored when full, pop ignored when empty.
module tcdm_varlat_id_fifo
    import tcdm_varlat_pkg::*;
#(
    parameter  int unsigned Depth  = 4,
    parameter  int unsigned Width  = 2,
    localparam int unsigned UsageW = $clog2(Depth + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [Width-1:0]  data_i,
    input  logic              pop_i,
    output logic [Width-1:0]  data_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [UsageW-1:0] usage_o
);

    localparam int unsigned PtrW = idx_width(Depth);

    logic [Depth-1:0][Width-1:0] mem_q;
    logic [PtrW-1:0]             wr_ptr_q, rd_ptr_q;
    logic [UsageW-1:0]           usage_q;
    logic                        do_push, do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (usage_q == UsageW'(Depth));
    assign empty_o = (usage_q == '0);
    assign usage_o = usage_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            usage_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   usage_q <= usage_q + UsageW'(1);
                2'b01:   usage_q <= usage_q - UsageW'(1);
                default: usage_q <= usage_q;
            endcase
        end
    end

endmodule

// File: rtl/tcdm_varlat_bank_arbiter.sv
// Round-robin per-bank arbiter that steers in-order bank responses back to the issuing master.
// Latency: request and response paths are combinational (zero cycles added).
// Backpressure: req_o drops while MaxOutstanding transactions are in flight; masters hold until gnt_o.
module tcdm_varlat_bank_arbiter
    import tcdm_varlat_pkg::*;
#(
    parameter  int unsigned NumIn          = 4,
    parameter  int unsigned ReqDataWidth   = 32,
    parameter  int unsigned RespDataWidth  = 32,
    parameter  int unsigned MaxOutstanding = MaxOutstandingDefault,
    localparam int unsigned IdxW           = idx_width(NumIn),
    localparam int unsigned CntW           = $clog2(MaxOutstanding + 1)
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [NumIn-1:0]                      req_i,
    input  logic [NumIn-1:0][ReqDataWidth-1:0]    data_i,
    output logic [NumIn-1:0]                      gnt_o,
    output logic [NumIn-1:0]                      vld_o,
    output logic [RespDataWidth-1:0]              rdata_o,
    output logic                                  req_o,
    output logic [ReqDataWidth-1:0]               data_o,
    input  logic                                  gnt_i,
    input  logic                                  vld_i,
    input  logic [RespDataWidth-1:0]              rdata_i,
    output logic [CntW-1:0]                       outstanding_o,
    output logic                                  err_o
);

    if (NumIn == 0 || MaxOutstanding == 0) begin : g_bad_params
        $fatal(1, "tcdm_varlat_bank_arbiter: NumIn and MaxOutstanding must both be >= 1");
    end

    // With a single master the pointer is one bit that never leaves zero.
    logic [IdxW-1:0] rr_q;
    logic [IdxW-1:0] winner, head_idx;
    logic            found, full, empty, xfer, pop, err_q;

    function automatic logic [IdxW-1:0] wrap_idx(input logic [IdxW-1:0] base,
                                                 input int unsigned    off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NumIn) s = s - NumIn;
        return IdxW'(s);
    endfunction

    always_comb begin
        winner = rr_q;
        found  = 1'b0;
        for (int unsigned i = 0; i < NumIn; i++) begin
            if (!found && req_i[wrap_idx(rr_q, i)]) begin
                winner = wrap_idx(rr_q, i);
                found  = 1'b1;
            end
        end
    end

    // Full is a registered condition, so a pop cannot re-open the request path this cycle.
    assign req_o   = found && !full;
    assign data_o  = data_i[winner];
    assign xfer    = req_o && gnt_i;
    assign gnt_o   = xfer ? (NumIn'(1) << winner) : '0;

    assign pop     = vld_i && !empty;
    assign vld_o   = pop ? (NumIn'(1) << head_idx) : '0;
    assign rdata_o = rdata_i;
    assign err_o   = err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q  <= '0;
            err_q <= 1'b0;
        end else begin
            if (xfer)           rr_q  <= wrap_idx(winner, 1);
            if (vld_i && empty) err_q <= 1'b1;
        end
    end

    tcdm_varlat_id_fifo #(
        .Depth (MaxOutstanding),
        .Width (IdxW)
    ) i_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (xfer),
        .data_i  (winner),
        .pop_i   (pop),
        .data_o  (head_idx),
        .full_o  (full),
        .empty_o (empty),
        .usage_o (outstanding_o)
    );

endmodule

// File: tb/tb_tcdm_varlat_bank_arbiter.sv
// Bench for tcdm_varlat_bank_arbiter: queue-based reference model plus directed and random traffic.
module tb_tcdm_varlat_bank_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int RW = 32;
    localparam int MO = 4;

    logic                   clk = 1'b0;
    logic                   rst_r;
    logic [N-1:0]           req_r;
    logic [N-1:0][DW-1:0]   data_r;
    logic                   gnt_r, vld_r;
    logic [RW-1:0]          rdata_r;
    logic [N-1:0]           gnt_o, vld_o;
    logic [RW-1:0]          rdata_o;
    logic                   req_o;
    logic [DW-1:0]          data_o;
    logic [2:0]             outstanding_o;
    logic                   err_o;

    always #5 clk = ~clk;

    tcdm_varlat_bank_arbiter #(
        .NumIn          (N),
        .ReqDataWidth   (DW),
        .RespDataWidth  (RW),
        .MaxOutstanding (MO)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_r),
        .req_i         (req_r),
        .data_i        (data_r),
        .gnt_o         (gnt_o),
        .vld_o         (vld_o),
        .rdata_o       (rdata_o),
        .req_o         (req_o),
        .data_o        (data_o),
        .gnt_i         (gnt_r),
        .vld_i         (vld_r),
        .rdata_i       (rdata_r),
        .outstanding_o (outstanding_o),
        .err_o         (err_o)
    );

    // Reference model: pointer, queue of granted master ids, sticky error.
    int rr;
    int mq[$];
    bit merr;
    // Bench-side bank: due cycle of each pending response, kept in issue order.
    int pend[$];
    int cyc, last_resp, lat_lo, lat_hi, last_w;
    bit bank_auto, chk_en;
    int checks, errors;
    logic [N-1:0] obs_gnt, obs_vld;
    logic         obs_req;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One clock cycle: inputs are set at the negedge, outputs checked 2 time units later.
    task automatic step();
        int sz, w, idx, due;
        bit any, full, xreq, xfer;
        logic [N-1:0] egnt, evld;
        logic [N-1:0] one;
        one = 4'b0001;
        if (bank_auto) vld_r = (pend.size() > 0 && pend[0] <= cyc);
        #2;
        sz   = mq.size();
        full = (sz >= MO);
        w    = rr;
        any  = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = (rr + i) % N;
            if (!any && req_r[idx]) begin
                w   = idx;
                any = 1'b1;
            end
        end
        xreq = any && !full;
        xfer = xreq && gnt_r;
        egnt = xfer ? (one << w) : '0;
        evld = '0;
        if (vld_r && sz > 0) evld = one << mq[0];
        if (chk_en) begin
            chk("req_o", 64'(req_o), 64'(xreq));
            if (xreq) chk("data_o", 64'(data_o), 64'(data_r[w]));
            chk("gnt_o", 64'(gnt_o), 64'(egnt));
            chk("vld_o", 64'(vld_o), 64'(evld));
            chk("rdata_o", 64'(rdata_o), 64'(rdata_r));
            chk("outstanding_o", 64'(outstanding_o), 64'(sz));
            chk("err_o", 64'(err_o), 64'(merr));
        end
        obs_gnt = gnt_o;
        obs_vld = vld_o;
        obs_req = req_o;
        @(posedge clk);
        if (rst_r) begin
            mq.delete();
            pend.delete();
            rr        = 0;
            merr      = 1'b0;
            last_resp = 0;
        end else begin
            if (vld_r) begin
                if (sz > 0) void'(mq.pop_front());
                else        merr = 1'b1;
                if (bank_auto && pend.size() > 0) void'(pend.pop_front());
            end
            if (xfer) begin
                mq.push_back(w);
                rr = (w + 1) % N;
                if (bank_auto) begin
                    due = cyc + int'($urandom_range(lat_hi, lat_lo));
                    if (due <= last_resp) due = last_resp + 1;
                    last_resp = due;
                    pend.push_back(due);
                end
            end
        end
        last_w = xfer ? w : -1;
        @(negedge clk);
        cyc++;
    endtask

    // Idle the masters and let every outstanding response come back.
    task automatic drain();
        req_r = '0;
        gnt_r = 1'b0;
        for (int i = 0; i < 60 && mq.size() > 0; i++) begin
            if (!bank_auto) vld_r = 1'b1;
            step();
        end
        vld_r = 1'b0;
        chk("drain_outstanding", 64'(outstanding_o), 64'd0);
    endtask

    initial begin
        int ngnt;
        logic [N-1:0] one;
        logic [N-1:0] t2_seq [4];
        one = 4'b0001;
        t2_seq = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
        checks = 0; errors = 0; cyc = 0; rr = 0; merr = 1'b0;
        last_resp = 0; lat_lo = 1; lat_hi = 1; last_w = -1;
        bank_auto = 1'b0; chk_en = 1'b0;
        rst_r = 1'b1; req_r = '0; data_r = '0; gnt_r = 1'b0; vld_r = 1'b0; rdata_r = '0;
        @(negedge clk);
        step();
        chk_en = 1'b1;
        step();
        rst_r = 1'b0;
        step();
        chk("reset_outstanding", 64'(outstanding_o), 64'd0);
        chk("reset_err", 64'(err_o), 64'd0);
        chk("reset_req", 64'(obs_req), 64'd0);

        // All four request, bank answers after one cycle.
        bank_auto = 1'b1; lat_lo = 1; lat_hi = 1;
        req_r = 4'b1111; gnt_r = 1'b1;
        for (int k = 0; k < 4; k++) begin
            for (int m = 0; m < N; m++) data_r[m] = $urandom;
            rdata_r = $urandom;
            step();
            chk("t1_gnt_order", 64'(obs_gnt), 64'(one << k));
            if (k > 0) chk("t1_vld_route", 64'(obs_vld), 64'(one << (k - 1)));
        end
        drain();

        // Two idle masters must be skipped.
        req_r = 4'b1010; gnt_r = 1'b1;
        for (int k = 0; k < 4; k++) begin
            rdata_r = $urandom;
            step();
            chk("t2_gnt_alt", 64'(obs_gnt), 64'(t2_seq[k]));
        end
        drain();

        // Silent bank: FIFO fills, request path closes.
        bank_auto = 1'b0; vld_r = 1'b0;
        req_r = 4'b1111; gnt_r = 1'b1; ngnt = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (obs_gnt != '0) ngnt++;
        end
        chk("t3_grant_count", 64'(ngnt), 64'd4);
        chk("t3_req_full", 64'(obs_req), 64'd0);
        chk("t3_outstanding_full", 64'(outstanding_o), 64'd4);
        vld_r = 1'b1;
        step();
        chk("t3_req_same_cycle_pop", 64'(obs_req), 64'd0);
        chk("t3_vld_head", 64'(obs_vld), 64'(4'b0001));
        vld_r = 1'b0;
        step();
        chk("t3_req_after_pop", 64'(obs_req), 64'd1);
        drain();

        // Response with nothing in flight.
        req_r = '0; gnt_r = 1'b0; vld_r = 1'b1;
        step();
        chk("t4_vld_empty", 64'(obs_vld), 64'd0);
        vld_r = 1'b0;
        step();
        chk("t4_err_sticky", 64'(err_o), 64'd1);
        chk("t4_outstanding", 64'(outstanding_o), 64'd0);
        step();
        chk("t4_err_still", 64'(err_o), 64'd1);

        // Reset with three transactions in flight.
        req_r = 4'b1111; gnt_r = 1'b1;
        for (int k = 0; k < 3; k++) step();
        chk("t5_outstanding_3", 64'(outstanding_o), 64'd3);
        rst_r = 1'b1; req_r = '0; gnt_r = 1'b0;
        step();
        rst_r = 1'b0;
        chk("t5_outstanding_rst", 64'(outstanding_o), 64'd0);
        chk("t5_err_rst", 64'(err_o), 64'd0);
        req_r = 4'b1111; gnt_r = 1'b1;
        step();
        chk("t5_rr_restart", 64'(obs_gnt), 64'(4'b0001));
        drain();

        // Random traffic, random bank latency 1..6.
        bank_auto = 1'b1; lat_lo = 1; lat_hi = 6;
        req_r = '0;
        for (int c = 0; c < 3000; c++) begin
            gnt_r   = ($urandom_range(3, 0) != 0);
            rdata_r = $urandom;
            for (int m = 0; m < N; m++) begin
                if (!req_r[m] && $urandom_range(2, 0) == 0) begin
                    req_r[m]  = 1'b1;
                    data_r[m] = $urandom;
                end
            end
            step();
            if (last_w >= 0) req_r[last_w] = 1'b0;
        end
        drain();
        chk("final_err", 64'(err_o), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
